// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank.
// Holds the frame FSM states, the frame geometry and the header field layout.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    DONE   = 2'd3
  } spi_state_e;

  // Header byte layout: RW flag in the MSB, address in the low bits.
  localparam int RW_BIT       = 7;
  localparam int HDR_ADDR_LSB = 0;

  // A frame is a header byte followed by a data byte.
  localparam int BYTE_BITS  = 8;
  localparam int FRAME_BITS = 16;

  // MSB position of the address field for a given address width.
  function automatic int hdr_addr_msb(input int addr_w);
    return HDR_ADDR_LSB + addr_w - 1;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the host (master) and the register bank (slave).
interface spi_reg_bank_if;

  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport slave (
    input  spi_cs_n,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso
  );

  modport master (
    output spi_cs_n,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso
  );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized value. All flops reset to 0.
module spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank.
// Frame: header byte (RW, address) then data byte, MSB first.
// Optional feature macro: SPI_RO_STATUS_EN -- when defined, the top address
// reads status_i and ignores writes (its reg_o slice stays 0).
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  localparam int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] reg_o,
  input  logic [DATA_W-1:0]          status_i,
  output logic                       wr_strobe_o,
  output logic [ADDR_W-1:0]          wr_addr_o
);

  localparam int CNT_W    = $clog2(FRAME_BITS);
  localparam int ADDR_MSB = hdr_addr_msb(ADDR_W);
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(BYTE_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  // Synchronized pins and edge pulses
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;

  spi_sync u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi.spi_cs_n),
    .o_q    (w_cs_q),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_sync u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi.spi_sclk),
    .o_q    (w_sclk_q),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi.spi_mosi),
    .o_q    (w_mosi_q),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  // Edge outputs not needed here: cs_n high is handled by level, mosi by sampling.
  logic w_unused_edges;
  assign w_unused_edges = w_cs_rise ^ w_mosi_rise ^ w_mosi_fall ^ w_sclk_q;

  // State and storage
  spi_state_e               r_state;
  spi_state_e               w_state_next;
  logic [DATA_W-2:0]        r_shift;
  logic [CNT_W-1:0]         r_bit_cnt;
  logic                     r_rw;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_tx;
  logic                     r_miso;
  logic [DATA_W-1:0]        r_regs [NUM_REGS];
  logic                     r_wr_strobe;
  logic [ADDR_W-1:0]        r_wr_addr;

  // Byte as it will look once the current rising-edge bit is shifted in.
  logic [DATA_W-1:0]        w_byte;
  logic [ADDR_W-1:0]        w_hdr_addr;
  logic [DATA_W-1:0]        w_rd_data;
  logic                     w_wr_en;
  logic                     w_hdr_done;
  logic                     w_data_done;

  assign w_byte      = {r_shift, w_mosi_q};
  assign w_hdr_addr  = w_byte[ADDR_MSB:HDR_ADDR_LSB];
  assign w_hdr_done  = (r_state == HEADER) && w_sclk_rise && !w_cs_q &&
                       (r_bit_cnt == HDR_LAST);
  assign w_data_done = (r_state == DATA) && w_sclk_rise && !w_cs_q &&
                       (r_bit_cnt == FRAME_LAST);

`ifdef SPI_RO_STATUS_EN
  localparam logic [ADDR_W-1:0] RO_ADDR = ADDR_W'(NUM_REGS - 1);
  // The top address is a window onto the core's status byte.
  assign w_rd_data = (w_hdr_addr == RO_ADDR) ? status_i : r_regs[w_hdr_addr];
  assign w_wr_en   = (r_addr != RO_ADDR);
`else
  assign w_rd_data = r_regs[w_hdr_addr];
  assign w_wr_en   = 1'b1;
  logic w_unused_status;
  assign w_unused_status = ^status_i;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; cs_n high aborts any frame back to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall)   w_state_next = HEADER;
      HEADER:  if (w_hdr_done)  w_state_next = DATA;
      DATA:    if (w_data_done) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
    if (w_cs_q) begin
      w_state_next = IDLE;
    end
  end

  // Frame datapath: RX shift, bit counter, header latch and TX shift to miso.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
    end else if (w_cs_q || (r_state == IDLE)) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
    end else begin
      if (w_sclk_rise && ((r_state == HEADER) || (r_state == DATA))) begin
        r_shift   <= w_byte[DATA_W-2:0];
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_hdr_done) begin
        r_rw   <= w_byte[RW_BIT];
        r_addr <= w_hdr_addr;
        // Read data is frozen here; later register changes are not seen.
        r_tx   <= w_byte[RW_BIT] ? '0 : w_rd_data;
      end
      if (w_sclk_fall && (r_state == DATA)) begin
        r_miso <= r_tx[DATA_W-1];
        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Register bank: commit a completed write frame and pulse the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_data_done && r_rw) begin
        r_wr_strobe <= 1'b1;
        r_wr_addr   <= r_addr;
        if (w_wr_en) begin
          r_regs[r_addr] <= w_byte;
        end
      end
    end
  end

  // Flatten the bank; a read-only slot is never written so its slice stays 0.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
    assign reg_o[gi*DATA_W +: DATA_W] = r_regs[gi];
  end

  assign spi.spi_miso = r_miso;
  assign wr_strobe_o  = r_wr_strobe;
  assign wr_addr_o    = r_wr_addr;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: stimulus pushes expected writes/reads,
// monitors pop and compare when the DUT strobes or a read byte arrives.
module tb_spi_reg_bank;

  localparam int NR = 8;
  localparam int HP = 60;  // half sclk period (ns); clk period is 10 ns

`ifdef SPI_RO_STATUS_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] reg_o;
  logic [7:0]  status_i;
  logic        wr_strobe_o;
  logic [2:0]  wr_addr_o;

  always #5 clk = ~clk;

  spi_reg_bank_if bus ();

  spi_reg_bank #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (bus.slave),
    .reg_o       (reg_o),
    .status_i    (status_i),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o)
  );

  // Reference model and scoreboard
  typedef struct {
    logic [2:0]  addr;
    logic [63:0] regs;
  } wr_exp_t;

  logic [7:0] mdl [NR];
  wr_exp_t    exp_wr [$];
  logic [7:0] exp_rd [$];
  int         exp_strobes = 0;
  int         got_strobes = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] rx_byte;
  event       rd_ev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] flat();
    logic [63:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = mdl[i];
    return f;
  endfunction

  function automatic bit is_ro(input logic [2:0] a);
    return RO_EN && (a == 3'(NR - 1));
  endfunction

  // Bit-bang one frame; optionally pulse reset just before bit rst_at.
  task automatic spi_xfer(input logic [23:0] bits, input int nbits, input int rst_at,
                          output logic [7:0] rx);
    rx = 8'h00;
    bus.spi_cs_n = 1'b0;
    #HP;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #40;
        rst_n = 1'b1;
      end
      bus.spi_mosi = bits[23-i];
      #HP;
      bus.spi_sclk = 1'b1;
      if (i >= 8 && i < 16) rx = {rx[6:0], bus.spi_miso};
      #HP;
      bus.spi_sclk = 1'b0;
    end
    #HP;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    #(2*HP);
  endtask

  task automatic op_write(input logic [2:0] a, input logic [7:0] d, input int nbits);
    logic [7:0] hdr;
    logic [7:0] rx;
    hdr = {1'b1, 4'($urandom), a};
    if (!is_ro(a)) mdl[a] = d;
    exp_wr.push_back('{addr: a, regs: flat()});
    exp_strobes++;
    $display("WRITE addr=%0d data=0x%02h bits=%0d", a, d, nbits);
    spi_xfer({hdr, d, 8'($urandom)}, nbits, -1, rx);
  endtask

  task automatic op_read(input logic [2:0] a);
    logic [7:0] hdr;
    logic [7:0] rx;
    hdr = {1'b0, 4'($urandom), a};
    exp_rd.push_back(is_ro(a) ? status_i : mdl[a]);
    spi_xfer({hdr, 8'($urandom), 8'h00}, 16, -1, rx);
    $display("READ  addr=%0d data=0x%02h", a, rx);
    rx_byte = rx;
    -> rd_ev;
  endtask

  task automatic op_abort(input logic [7:0] hdr, input logic [7:0] d, input int nbits);
    logic [7:0] rx;
    $display("ABORT hdr=0x%02h data=0x%02h after %0d bits", hdr, d, nbits);
    spi_xfer({hdr, d, 8'h00}, nbits, -1, rx);
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wr_strobe_o === 1'b1) begin
        got_strobes++;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got strobe with wr_addr=%0d, expected none", wr_addr_o);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(wr_addr_o), 64'(e.addr));
          check("reg_o_at_strobe", reg_o, e.regs);
        end
        @(negedge clk);
        check("strobe_width", 64'(wr_strobe_o), 64'd0);
      end
    end
  end

  // Read monitor: every received byte must match the oldest expected read.
  initial begin
    forever begin
      @(rd_ev);
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%0h, expected nothing", rx_byte);
      end else begin
        check("rd_data", 64'(rx_byte), 64'(exp_rd.pop_front()));
      end
    end
  end

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish, expected finish before 3 ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    int         r;
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    status_i     = 8'h3C;
    rst_n        = 1'b0;
    #100;
    rst_n = 1'b1;
    #100;

    // Reset state
    check("reset_reg_o", reg_o, 64'd0);
    check("reset_miso", 64'(bus.spi_miso), 64'd0);
    check("reset_wr_addr", 64'(wr_addr_o), 64'd0);
    check("reset_strobe", 64'(wr_strobe_o), 64'd0);

    // Basic write / read-back
    op_write(3'd2, 8'hA5, 16);
    check("reg2_after_write", 64'(reg_o[23:16]), 64'hA5);
    op_read(3'd2);
    check("miso_idle_after_read", 64'(bus.spi_miso), 64'd0);
    check("reg_o_after_read", reg_o, flat());

    // Read-only status window
    if (RO_EN) begin
      op_read(3'd7);
      op_write(3'd7, 8'hFF, 16);
      check("reg_o_after_ro_write", reg_o, flat());
    end

    // Partial frame after 11 bits: no commit, next frame clean
    op_abort(8'h81, 8'h5A, 11);
    check("reg_o_after_abort", reg_o, flat());
    op_write(3'd1, 8'h5A, 16);
    op_read(3'd1);

    // Reset mid data byte of a write to addr 0, then a 24-bit frame
    $display("RESET mid-frame write addr=0 data=0x77");
    spi_xfer({8'h80, 8'h77, 8'h00}, 16, 12, rx);
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    check("reg_o_after_midframe_reset", reg_o, 64'd0);
    check("wr_addr_after_midframe_reset", 64'(wr_addr_o), 64'd0);
    op_write(3'd3, 8'hC3, 24);
    check("reg_o_after_24bit", reg_o, flat());
    op_read(3'd3);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        op_write(3'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1) ? 24 : 16);
      end else if (r < 8) begin
        if (r == 7) status_i = 8'($urandom);
        op_read(3'($urandom));
      end else begin
        op_abort(8'($urandom), 8'($urandom), int'($urandom_range(1, 15)));
      end
    end
    check("reg_o_final", reg_o, flat());

    #500;
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    check("strobe_count", 64'(got_strobes), 64'(exp_strobes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
